guess_check_unit: RTL and testbench
===================================

Name: guess_check_unit

Overview:
- Datapath stage directly downstream of the hangman control FSM.
- Stores the secret word that the setter types in and latches each guess. It scans the word sequentially, then returns the match, filled, continuous and complete feedback that the FSM consumes.
- Also owns the revealed-letter mask and the miss counter, which are exported to the VGA/HEX display logic.

Parameters:
- MAX_LEN, 16, maximum secret-word length in characters.
- CHAR_W, 5, character code width; 0–25 = a–z, other codes are invalid.
- MAX_MISS, 6, misses that end the game (one per gallows part).

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- clear  in  1  synchronous game wipe; same effect as reset
- ld  in  1  FSM word-entry state (S_LOAD_C) active
- wr_char  in  1  one-cycle strobe: append char_in to the word
- char_in  in  CHAR_W  character from keyboard decoder
- ldguessinput  in  1  FSM: latch char_in as the current guess
- fill  in  1  FSM fill-blank state active
- draw  in  1  FSM draw state active
- match  out  1  last scanned guess occurs in the word
- filled  out  1  one-cycle pulse: reveal applied
- continuous  out  1  at least one unrevealed position remains
- complete  out  1  miss count has reached MAX_MISS
- busy  out  1  scan in progress
- word_len  out  $clog2(MAX_LEN+1)  stored length
- revealed  out  MAX_LEN  per-position reveal mask
- miss_count  out  3  misses so far

Behaviour:
- Reset, or clear=1 for one cycle, zeroes the following:
  - word storage, word_len, revealed, miss_count, guess register, scan mask
  - match, filled, busy
- After reset, continuous=0 (because word_len=0) and complete=0.
- Word load:
  - When ld=1, wr_char=1 and word_len<MAX_LEN, char_in is written at index word_len and word_len increments next cycle.
  - Writes are ignored when word_len=MAX_LEN, when char_in>25, or when ld=0.
- Guess latch: when ldguessinput=1 and busy=0, char_in is registered as guess. If char_in≤25, the next cycle enters state SCAN.
- States:
  - IDLE:
    - ldguessinput with a valid char → SCAN, with idx=0, busy=1, the scan mask cleared and match cleared.
    - ldguessinput is ignored while busy=1.
  - SCAN:
    - One position per cycle: if idx<word_len and word[idx]==guess, set scan_mask[idx]=1.
    - At idx=MAX_LEN-1 → DONE. Latency is always MAX_LEN cycles, independent of word_len.
  - DONE:
    - match := OR of scan_mask, registered for one cycle.
    - busy=0 and the state returns to IDLE.
    - match holds until the next scan starts.
- Fill: on the rising edge of fill (fill=1 with fill_q=0):
  - revealed |= scan_mask.
  - filled pulses high exactly one cycle later.
  - fill held high does not re-pulse filled.
  - The FSM consumes filled, then continuous.
- continuous = (word_len>0) and (revealed[word_len-1:0] is not all ones); combinational from registers.
- Repeat of a correct letter: match=1, revealed unchanged; this is not a miss.
- Draw: on the rising edge of draw, miss_count increments, saturating at MAX_MISS. A repeated wrong letter counts again.
- complete = (miss_count ≥ MAX_MISS), registered; it is valid in the cycle after the increment.
- Simultaneous events:
  - clear has priority over all other inputs.
  - A fill edge that coincides with a scan start uses the previous scan_mask. This cannot occur in the FSM order, but the behaviour is defined.
  - A draw edge while busy=1 still counts.
- Mid-operation reset aborts the scan; all outputs return to their reset values within the reset assertion.
- Word entry after a guess (ld=1 again without clear) appends to the word; revealed is unaffected.

Decomposition:
- Shared package hangman_pkg holds the following, reused by the FSM and display:
  - CHAR_W, MAX_LEN, MAX_MISS
  - character code constants CH_A…CH_Z and CH_INVALID
  - the scan state typedef {IDLE, SCAN, DONE}
- One natural sub-module: edge_pulse, the rising-edge detector used for fill and draw. Word storage is a register array with no separate memory module.

Test Plan:
- Load "cab" (2,0,1), then guess 'a'(0): busy is high for 16 cycles, then match=1; fill edge → revealed=16'b0000_0000_0000_0010, filled pulses once, continuous=1.
- Same word, guess 'c', fill, then guess 'b', fill: revealed=0x0007 and continuous=0 in the cycle after the second filled.
- Guess 'z'(25) on "cab": match=0. Six draw rising edges → miss_count 1…6, complete=1 after the sixth; a seventh edge leaves miss_count=6.
- Load 17 chars with MAX_LEN=16: word_len saturates at 16. char_in=27 with wr_char is ignored. ldguessinput=1 during busy leaves the guess unchanged.
- Word "aa", guess 'a' → scan_mask=0x0003, and a single fill reveals both positions. Repeat guess 'a' → match=1, with no miss and no revealed change.
- resetn low mid-scan (cycle 7), or clear pulse after a win: busy=0, match=0, revealed=0, miss_count=0, word_len=0, complete=0 immediately (or next cycle for clear).

Source files
------------

// File: rtl/hangman_pkg.sv
// rtl/hangman_pkg.sv - shared hangman constants, character codes and scan state type
package hangman_pkg;

    localparam int CHAR_W   = 5;
    localparam int MAX_LEN  = 16;
    localparam int MAX_MISS = 6;

    localparam logic [CHAR_W-1:0] CH_A = 5'd0;
    localparam logic [CHAR_W-1:0] CH_B = 5'd1;
    localparam logic [CHAR_W-1:0] CH_C = 5'd2;
    localparam logic [CHAR_W-1:0] CH_D = 5'd3;
    localparam logic [CHAR_W-1:0] CH_E = 5'd4;
    localparam logic [CHAR_W-1:0] CH_F = 5'd5;
    localparam logic [CHAR_W-1:0] CH_G = 5'd6;
    localparam logic [CHAR_W-1:0] CH_H = 5'd7;
    localparam logic [CHAR_W-1:0] CH_I = 5'd8;
    localparam logic [CHAR_W-1:0] CH_J = 5'd9;
    localparam logic [CHAR_W-1:0] CH_K = 5'd10;
    localparam logic [CHAR_W-1:0] CH_L = 5'd11;
    localparam logic [CHAR_W-1:0] CH_M = 5'd12;
    localparam logic [CHAR_W-1:0] CH_N = 5'd13;
    localparam logic [CHAR_W-1:0] CH_O = 5'd14;
    localparam logic [CHAR_W-1:0] CH_P = 5'd15;
    localparam logic [CHAR_W-1:0] CH_Q = 5'd16;
    localparam logic [CHAR_W-1:0] CH_R = 5'd17;
    localparam logic [CHAR_W-1:0] CH_S = 5'd18;
    localparam logic [CHAR_W-1:0] CH_T = 5'd19;
    localparam logic [CHAR_W-1:0] CH_U = 5'd20;
    localparam logic [CHAR_W-1:0] CH_V = 5'd21;
    localparam logic [CHAR_W-1:0] CH_W = 5'd22;
    localparam logic [CHAR_W-1:0] CH_X = 5'd23;
    localparam logic [CHAR_W-1:0] CH_Y = 5'd24;
    localparam logic [CHAR_W-1:0] CH_Z = 5'd25;
    localparam logic [CHAR_W-1:0] CH_INVALID = 5'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

endpackage

// File: rtl/edge_pulse.sv
// rtl/edge_pulse.sv - rising-edge detector for FSM level signals
module edge_pulse (
    input  logic clk,
    input  logic resetn,
    input  logic clear_i,
    input  logic level_i,
    output logic pulse_o
);

    logic level_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            level_q <= 1'b0;
        end else if (clear_i) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_i;
        end
    end

    assign pulse_o = level_i & ~level_q;

endmodule

// File: rtl/guess_check_unit.sv
// rtl/guess_check_unit.sv - secret word store, sequential guess scan, reveal mask and miss counter
module guess_check_unit
    import hangman_pkg::*;
#(
    parameter int MAX_LEN  = hangman_pkg::MAX_LEN,
    parameter int CHAR_W   = hangman_pkg::CHAR_W,
    parameter int MAX_MISS = hangman_pkg::MAX_MISS
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         clear,
    input  logic                         ld,
    input  logic                         wr_char,
    input  logic [CHAR_W-1:0]            char_in,
    input  logic                         ldguessinput,
    input  logic                         fill,
    input  logic                         draw,
    output logic                         match,
    output logic                         filled,
    output logic                         continuous,
    output logic                         complete,
    output logic                         busy,
    output logic [$clog2(MAX_LEN+1)-1:0] word_len,
    output logic [MAX_LEN-1:0]           revealed,
    output logic [2:0]                   miss_count
);

    localparam int LW = $clog2(MAX_LEN+1);
    localparam int IW = $clog2(MAX_LEN);
    localparam logic [CHAR_W-1:0] LAST_CH = CHAR_W'(25);

    logic [CHAR_W-1:0]  word_q [MAX_LEN];
    logic [LW-1:0]      len_q;
    logic [CHAR_W-1:0]  guess_q;
    scan_state_t        state_q;
    logic [IW-1:0]      idx_q;
    logic [MAX_LEN-1:0] scan_mask_q;
    logic [MAX_LEN-1:0] revealed_q;
    logic               match_q;
    logic               busy_q;
    logic               filled_q;
    logic               complete_q;
    logic [2:0]         miss_q;
    logic [2:0]         miss_d;

    logic fill_edge;
    logic draw_edge;
    logic char_ok;
    logic hit;
    logic all_revealed;

    edge_pulse u_fill_edge (
        .clk     (clk),
        .resetn  (resetn),
        .clear_i (clear),
        .level_i (fill),
        .pulse_o (fill_edge)
    );

    edge_pulse u_draw_edge (
        .clk     (clk),
        .resetn  (resetn),
        .clear_i (clear),
        .level_i (draw),
        .pulse_o (draw_edge)
    );

    assign char_ok = (char_in <= LAST_CH);
    // Positions beyond word_len may hold stale zeros ('a'), so gate on length.
    assign hit     = (LW'(idx_q) < len_q) && (word_q[idx_q] == guess_q);

    always_comb begin
        miss_d = miss_q;
        if (draw_edge && (miss_q < 3'(MAX_MISS))) begin
            miss_d = miss_q + 3'd1;
        end
    end

    always_comb begin
        all_revealed = 1'b1;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((LW'(i) < len_q) && !revealed_q[i]) begin
                all_revealed = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < MAX_LEN; i++) word_q[i] <= '0;
            len_q       <= '0;
            guess_q     <= '0;
            state_q     <= IDLE;
            idx_q       <= '0;
            scan_mask_q <= '0;
            revealed_q  <= '0;
            match_q     <= 1'b0;
            busy_q      <= 1'b0;
            filled_q    <= 1'b0;
            complete_q  <= 1'b0;
            miss_q      <= '0;
        end else if (clear) begin
            for (int i = 0; i < MAX_LEN; i++) word_q[i] <= '0;
            len_q       <= '0;
            guess_q     <= '0;
            state_q     <= IDLE;
            idx_q       <= '0;
            scan_mask_q <= '0;
            revealed_q  <= '0;
            match_q     <= 1'b0;
            busy_q      <= 1'b0;
            filled_q    <= 1'b0;
            complete_q  <= 1'b0;
            miss_q      <= '0;
        end else begin
            if (ld && wr_char && char_ok && (len_q < LW'(MAX_LEN))) begin
                for (int i = 0; i < MAX_LEN; i++) begin
                    if (LW'(i) == len_q) word_q[i] <= char_in;
                end
                len_q <= len_q + 1'b1;
            end

            case (state_q)
                IDLE, DONE: begin
                    state_q <= IDLE;
                    if (ldguessinput) begin
                        guess_q <= char_in;
                        if (char_ok) begin
                            state_q     <= SCAN;
                            idx_q       <= '0;
                            busy_q      <= 1'b1;
                            scan_mask_q <= '0;
                            match_q     <= 1'b0;
                        end
                    end
                end
                SCAN: begin
                    if (hit) scan_mask_q[idx_q] <= 1'b1;
                    idx_q <= idx_q + 1'b1;
                    // Fold the final position in directly so match lands as busy drops.
                    if (idx_q == IW'(MAX_LEN-1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        match_q <= (|scan_mask_q) | hit;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (fill_edge) revealed_q <= revealed_q | scan_mask_q;
            filled_q   <= fill_edge;
            miss_q     <= miss_d;
            complete_q <= (miss_d >= 3'(MAX_MISS));
        end
    end

    assign match      = match_q;
    assign filled     = filled_q;
    assign busy       = busy_q;
    assign complete   = complete_q;
    assign word_len   = len_q;
    assign revealed   = revealed_q;
    assign miss_count = miss_q;
    assign continuous = (len_q != '0) && !all_revealed;

endmodule

// File: tb/tb_guess_check_unit.sv
// tb/tb_guess_check_unit.sv - randomized self-checking bench for guess_check_unit
module tb_guess_check_unit;
    import hangman_pkg::*;

    localparam int LW = $clog2(MAX_LEN+1);

    logic              clk = 1'b0;
    logic              resetn, clear, ld, wr_char, ldguessinput, fill, draw;
    logic [CHAR_W-1:0] char_in;
    logic              match, filled, continuous, complete, busy;
    logic [LW-1:0]     word_len;
    logic [MAX_LEN-1:0] revealed;
    logic [2:0]        miss_count;

    guess_check_unit dut (
        .clk          (clk),
        .resetn       (resetn),
        .clear        (clear),
        .ld           (ld),
        .wr_char      (wr_char),
        .char_in      (char_in),
        .ldguessinput (ldguessinput),
        .fill         (fill),
        .draw         (draw),
        .match        (match),
        .filled       (filled),
        .continuous   (continuous),
        .complete     (complete),
        .busy         (busy),
        .word_len     (word_len),
        .revealed     (revealed),
        .miss_count   (miss_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int               m_word[$];
    logic [MAX_LEN-1:0] m_rev;
    logic [MAX_LEN-1:0] m_mask;
    int               m_miss;
    logic             m_match;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_wipe();
        m_word.delete();
        m_rev   = '0;
        m_mask  = '0;
        m_miss  = 0;
        m_match = 1'b0;
    endtask

    function automatic logic model_continuous();
        if (m_word.size() == 0) return 1'b0;
        foreach (m_word[i]) if (!m_rev[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_all(input string tag);
        check_val({tag, "/word_len"},   32'(word_len),   32'(m_word.size()));
        check_val({tag, "/revealed"},   32'(revealed),   32'(m_rev));
        check_val({tag, "/miss_count"}, 32'(miss_count), 32'(m_miss));
        check_val({tag, "/complete"},   32'(complete),   32'(m_miss >= MAX_MISS));
        check_val({tag, "/continuous"}, 32'(continuous), 32'(model_continuous()));
        check_val({tag, "/match"},      32'(match),      32'(m_match));
        check_val({tag, "/busy"},       32'(busy),       32'(0));
    endtask

    task automatic load_char(input int c, input logic ldv);
        ld = ldv; wr_char = 1'b1; char_in = CHAR_W'(c);
        tick();
        ld = 1'b0; wr_char = 1'b0;
        if (ldv && c <= 25 && m_word.size() < MAX_LEN) m_word.push_back(c);
    endtask

    task automatic load_word(input string s);
        for (int i = 0; i < s.len(); i++) load_char(int'(s[i]) - 97, 1'b1);
    endtask

    task automatic do_guess(input int c, input logic interfere);
        int n;
        ldguessinput = 1'b1; char_in = CHAR_W'(c);
        tick();
        ldguessinput = 1'b0;
        if (c > 25) begin
            check_val("invalid_guess_busy", 32'(busy), 32'(0));
            return;
        end
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            if (interfere && n == 3) begin
                ldguessinput = 1'b1;
                char_in = CHAR_W'((c + 1) % 26);
            end
            tick();
            ldguessinput = 1'b0;
        end
        check_val("busy_cycles", 32'(n), 32'(MAX_LEN));
        m_mask = '0;
        foreach (m_word[i]) if (m_word[i] == c) m_mask[i] = 1'b1;
        m_match = (m_mask != '0);
        check_val("match", 32'(match), 32'(m_match));
    endtask

    task automatic do_fill();
        fill = 1'b1;
        tick();
        m_rev = m_rev | m_mask;
        check_val("filled_pulse", 32'(filled), 32'(1));
        check_val("fill_revealed", 32'(revealed), 32'(m_rev));
        tick();
        check_val("filled_held", 32'(filled), 32'(0));
        fill = 1'b0;
        tick();
        check_val("filled_low", 32'(filled), 32'(0));
    endtask

    task automatic do_draw();
        draw = 1'b1;
        tick();
        if (m_miss < MAX_MISS) m_miss++;
        check_val("draw_miss", 32'(miss_count), 32'(m_miss));
        draw = 1'b0;
        tick();
        check_val("draw_complete", 32'(complete), 32'(m_miss >= MAX_MISS));
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_wipe();
    endtask

    initial begin
        resetn = 1'b0; clear = 1'b0; ld = 1'b0; wr_char = 1'b0; char_in = '0;
        ldguessinput = 1'b0; fill = 1'b0; draw = 1'b0;
        model_wipe();
        tick();
        tick();
        check_all("reset");
        resetn = 1'b1;
        tick();

        load_word("cab");
        check_all("load_cab");
        do_guess(0, 1'b0);
        do_fill();
        check_val("cab_a_revealed", 32'(revealed), 32'h0002);
        check_all("cab_a");

        do_guess(2, 1'b0);
        do_fill();
        do_guess(1, 1'b0);
        do_fill();
        check_val("cab_all_revealed", 32'(revealed), 32'h0007);
        check_all("cab_win");

        do_guess(25, 1'b0);
        for (int i = 0; i < 7; i++) do_draw();
        check_all("cab_z_draws");

        do_clear();
        check_all("clear_after_game");
        load_char(0, 1'b1);
        load_char(27, 1'b1);
        load_char(3, 1'b0);
        check_all("invalid_writes");
        for (int i = 0; i < 17; i++) load_char($urandom_range(0, 25), 1'b1);
        check_all("load_17");
        do_guess(int'(m_word[4]), 1'b1);
        check_all("guess_interfere");

        do_clear();
        load_word("aa");
        do_guess(0, 1'b0);
        do_fill();
        check_all("aa_fill");
        do_guess(0, 1'b0);
        do_fill();
        check_all("aa_repeat");

        do_clear();
        load_word("cab");
        ldguessinput = 1'b1; char_in = CHAR_W'(1);
        tick();
        ldguessinput = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        resetn = 1'b0;
        #1;
        model_wipe();
        check_all("midscan_reset");
        tick();
        resetn = 1'b1;
        tick();

        load_word("ab");
        do_guess(0, 1'b0);
        do_fill();
        do_guess(1, 1'b0);
        do_fill();
        check_all("ab_win");
        do_clear();
        check_all("clear_after_win");

        for (int g = 0; g < 8; g++) begin
            int nl;
            do_clear();
            nl = $urandom_range(1, 18);
            for (int i = 0; i < nl; i++)
                load_char(($urandom_range(0, 9) == 0) ? 27 : $urandom_range(0, 5), 1'b1);
            check_all("rand_load");
            for (int a = 0; a < 12; a++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r <= 4) begin
                    do_guess(($urandom_range(0, 7) == 0) ? $urandom_range(26, 27) : $urandom_range(0, 7),
                             1'($urandom_range(0, 1)));
                end else if (r <= 6) begin
                    do_fill();
                end else if (r <= 8) begin
                    do_draw();
                end else begin
                    load_char($urandom_range(0, 5), 1'b1);
                end
                check_all("rand_step");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
